// File: rtl/cic_pkg.sv
// Shared definitions for the stereo PDM CIC decimator sequencer.
//   state_t    : sequencer states (IDLE, CLEAR, RUN)
//   DATA_W_DEF : default sample width
//   settle_w() : width of a counter that holds 0..settle (at least 1 bit)
package cic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 24;

    function automatic int settle_w(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/cic_pdm_clkgen.sv
// PDM microphone clock generator and left/right sample strobes.
//   clk, reset : system clock, synchronous active-high reset
//   run        : 1 when the coming cycle is a RUN cycle
//   pdm_clk    : registered microphone clock, high for the first half period
//   take_l/r   : combinational, "sample pdm_data on this edge"
//   ce_int_l/r : registered one-cycle integrator strobes that follow take_l/r
module cic_pdm_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic pdm_clk,
    output logic take_l,
    output logic take_r,
    output logic ce_int_l,
    output logic ce_int_r
);

    localparam int CW   = $clog2(CLK_DIV);
    localparam int HALF = CLK_DIV / 2;

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] div_nxt;
    logic          active;   // current cycle is a RUN cycle

    // The first RUN cycle starts the divider at 0; pdm_clk is registered from
    // the value div_cnt is about to take so the two stay aligned.
    always_comb begin
        div_nxt = '0;
        if (run && active && div_cnt != CW'(CLK_DIV - 1))
            div_nxt = div_cnt + CW'(1);
    end

    assign take_l = run && active && (div_cnt == CW'(HALF - 1));
    assign take_r = run && active && (div_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            active   <= 1'b0;
            div_cnt  <= '0;
            pdm_clk  <= 1'b0;
            ce_int_l <= 1'b0;
            ce_int_r <= 1'b0;
        end else begin
            active   <= run;
            div_cnt  <= div_nxt;
            pdm_clk  <= run && (div_nxt < CW'(HALF));
            ce_int_l <= take_l;
            ce_int_r <= take_r;
        end
    end

endmodule

// File: rtl/cic_ctrl.sv
// Sequencer for a stereo PDM-microphone CIC decimator (single clock domain).
//   clk, reset          : system clock, synchronous active-high reset
//   enable, decim       : run request, decimation ratio minus one
//   pdm_clk, pdm_data   : microphone clock out, interleaved L/R data in
//   pdm_bit             : latched PDM bit for the integrators
//   dp_clear            : one-cycle clear of all integrators/combs
//   ce_int_l/r, ce_comb : integrator and comb clock enables
//   res_l/r             : comb outputs from the datapath
//   out_valid/ready/l/r : decimated sample pair handshake
//   overrun             : sticky, a pair was dropped while the port was full
module cic_ctrl
    import cic_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DECIM_W = 9,
    parameter int SETTLE  = 2,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DECIM_W-1:0] decim,
    output logic              pdm_clk,
    input  logic              pdm_data,
    output logic              pdm_bit,
    output logic              dp_clear,
    output logic              ce_int_l,
    output logic              ce_int_r,
    output logic              ce_comb,
    input  logic [DATA_W-1:0] res_l,
    input  logic [DATA_W-1:0] res_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_l,
    output logic [DATA_W-1:0] out_r,
    output logic              overrun
);

    localparam int SW = settle_w(SETTLE);

    state_t             state;
    state_t             next_state;
    logic               run;
    logic               take_l;
    logic               take_r;
    logic [DECIM_W-1:0] dec_max;
    logic [DECIM_W-1:0] dec_cnt;
    logic               cap_stb;
    logic [SW-1:0]      settle_cnt;

    cic_pdm_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .pdm_clk  (pdm_clk),
        .take_l   (take_l),
        .take_r   (take_r),
        .ce_int_l (ce_int_l),
        .ce_int_r (ce_int_r)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (enable) next_state = CLEAR;
            CLEAR:   next_state = enable ? RUN : IDLE;
            RUN:     if (!enable) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // run looks one cycle ahead so registered clkgen outputs line up with RUN.
    always_comb begin
        dp_clear = (state == CLEAR);
        run      = (next_state == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_max    <= '0;
            dec_cnt    <= '0;
            ce_comb    <= 1'b0;
            cap_stb    <= 1'b0;
            settle_cnt <= '0;
            pdm_bit    <= 1'b0;
            out_valid  <= 1'b0;
            out_l      <= '0;
            out_r      <= '0;
            overrun    <= 1'b0;
        end else begin
            // decim is only looked at when a run starts.
            if (state == IDLE && enable)
                dec_max <= decim;

            if (take_l || take_r)
                pdm_bit <= pdm_data;

            // ce_comb trails the wrapping ce_int_r by one cycle so both
            // integrators have taken their last input; capture trails ce_comb.
            if (!run) begin
                dec_cnt <= '0;
                ce_comb <= 1'b0;
                cap_stb <= 1'b0;
            end else begin
                ce_comb <= 1'b0;
                if (ce_int_r) begin
                    if (dec_cnt == dec_max) begin
                        dec_cnt <= '0;
                        ce_comb <= 1'b1;
                    end else begin
                        dec_cnt <= dec_cnt + DECIM_W'(1);
                    end
                end
                cap_stb <= ce_comb;
            end

            if (state == CLEAR)
                settle_cnt <= SW'(SETTLE);

            if (next_state == IDLE) begin
                out_valid <= 1'b0;
                overrun   <= 1'b0;
            end else if (cap_stb) begin
                if (settle_cnt != '0) begin
                    settle_cnt <= settle_cnt - SW'(1);   // start-up output, drop it
                end else if (out_valid && !out_ready) begin
                    overrun <= 1'b1;                     // keep the unread pair
                end else begin
                    out_l     <= res_l;
                    out_r     <= res_r;
                    out_valid <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
